// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer.
//   GS_*     : encodings driven on the external gameState bus
//   state_t  : internal sequencer state (RESTART is invisible on gameState)
//   SCORE_W / SPEED_W : widths of the score and speed-level buses
package game_pkg;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_RUN  = 2'b10;
    localparam logic [1:0] GS_DEAD = 2'b01;

    localparam int SCORE_W = 14;
    localparam int SPEED_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DEAD    = 2'd2,
        RESTART = 2'd3
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw asynchronous button, plus a one-cycle
// rising-edge pulse derived from the synchronized level.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_btn          : raw button input (asynchronous)
//   o_level        : synchronized button level
//   o_rise         : one-cycle pulse on a synchronized 0->1 transition
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer. Buttons and collision are sampled on every clk
// cycle into sticky per-frame flags; every decision (state, outputs, score,
// speed, lockout) is committed only on cycles where frame_tick is high, so
// all outputs are registered and stable for a whole frame.
// Ports:
//   clk, rst_n           : system clock, asynchronous active-low reset
//   frame_tick           : one-cycle pulse per video frame
//   btn_jump, btn_duck   : raw asynchronous buttons
//   collision            : overlap flag, any-cycle assertion counts
//   gameState            : 00 IDLE, 10 RUN, 01 DEAD (RESTART shows as 01)
//   jump, duck           : dino controls (jump lasts one frame)
//   game_rst             : one-frame datapath reset while restarting
//   score, hi_score      : binary score and best score
//   speed_lvl            : obstacle speed level
//   dbg_state            : internal sequencer state for observation
// Handshake: there is no valid/ready; every output is a level that is only
// allowed to change on the clk edge where frame_tick=1.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_DIV    = 6,
    parameter int SPEED_STEP   = 100,
    parameter int SPEED_MAX    = 7,
    parameter int DEAD_LOCKOUT = 30,
    parameter int SCORE_MAX    = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_jump,
    input  logic               btn_duck,
    input  logic               collision,
    output logic [1:0]         gameState,
    output logic               jump,
    output logic               duck,
    output logic               game_rst,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic [SPEED_W-1:0] speed_lvl,
    output state_t             dbg_state
);

    localparam int FW = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
    localparam int SW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam int LW = $clog2(DEAD_LOCKOUT + 1);

    localparam logic [FW-1:0]      FRAME_LAST = FW'(SCORE_DIV - 1);
    localparam logic [SW-1:0]      STEP_LAST  = SW'(SPEED_STEP - 1);
    localparam logic [LW-1:0]      LOCK_LOAD  = LW'(DEAD_LOCKOUT);
    localparam logic [SCORE_W-1:0] SCORE_SAT  = SCORE_W'(SCORE_MAX);
    localparam logic [SPEED_W-1:0] SPEED_SAT  = SPEED_W'(SPEED_MAX);

    logic w_jump_lvl, w_jump_rise;
    logic w_duck_lvl, w_duck_rise;
    logic w_unused;

    btn_sync_edge u_sync_jump (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_jump),
        .o_level (w_jump_lvl),
        .o_rise  (w_jump_rise)
    );

    btn_sync_edge u_sync_duck (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_duck),
        .o_level (w_duck_lvl),
        .o_rise  (w_duck_rise)
    );

    // Jump level and duck edge are not needed by the sequencer.
    assign w_unused = w_jump_lvl ^ w_duck_rise;

    logic r_jump_pend, r_coll_pend;
    logic w_jump_evt,  w_coll_evt;

    // An edge landing on the tick cycle itself still belongs to this frame.
    assign w_jump_evt = r_jump_pend | w_jump_rise;
    assign w_coll_evt = r_coll_pend | collision;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jump_pend <= 1'b0;
            r_coll_pend <= 1'b0;
        end else if (frame_tick) begin
            r_jump_pend <= 1'b0;
            r_coll_pend <= 1'b0;
        end else begin
            if (w_jump_rise) r_jump_pend <= 1'b1;
            if (collision)   r_coll_pend <= 1'b1;
        end
    end

    state_t             r_state;
    logic [1:0]         r_game_state;
    logic               r_jump, r_duck, r_game_rst;
    logic [SCORE_W-1:0] r_score, r_hi_score;
    logic [SPEED_W-1:0] r_speed;
    logic [FW-1:0]      r_frame_cnt;
    logic [SW-1:0]      r_step_cnt;
    logic [LW-1:0]      r_lock_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_game_state <= GS_IDLE;
            r_jump       <= 1'b0;
            r_duck       <= 1'b0;
            r_game_rst   <= 1'b0;
            r_score      <= '0;
            r_hi_score   <= '0;
            r_speed      <= '0;
            r_frame_cnt  <= '0;
            r_step_cnt   <= '0;
            r_lock_cnt   <= '0;
        end else if (frame_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_jump_evt) begin
                        r_state      <= RUN;
                        r_game_state <= GS_RUN;
                        r_jump       <= 1'b1;
                        r_score      <= '0;
                        r_speed      <= '0;
                        r_frame_cnt  <= '0;
                        r_step_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (w_coll_evt) begin
                        // Collision wins; a jump in the same frame is dropped
                        // and the score of this frame is not advanced.
                        r_state      <= DEAD;
                        r_game_state <= GS_DEAD;
                        r_jump       <= 1'b0;
                        r_duck       <= 1'b0;
                        r_lock_cnt   <= LOCK_LOAD;
                        if (r_score > r_hi_score) r_hi_score <= r_score;
                    end else begin
                        r_jump <= w_jump_evt;
                        r_duck <= w_duck_lvl;
                        // A saturated score freezes both counters.
                        if (r_score != SCORE_SAT) begin
                            if (r_frame_cnt == FRAME_LAST) begin
                                r_frame_cnt <= '0;
                                r_score     <= r_score + 1'b1;
                                if (r_step_cnt == STEP_LAST) begin
                                    r_step_cnt <= '0;
                                    if (r_speed != SPEED_SAT) r_speed <= r_speed + 1'b1;
                                end else begin
                                    r_step_cnt <= r_step_cnt + 1'b1;
                                end
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                            end
                        end
                    end
                end
                DEAD: begin
                    if (r_lock_cnt != '0) begin
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                    end else if (w_jump_evt) begin
                        r_state     <= RESTART;
                        r_game_rst  <= 1'b1;
                        r_score     <= '0;
                        r_speed     <= '0;
                        r_frame_cnt <= '0;
                        r_step_cnt  <= '0;
                    end
                end
                RESTART: begin
                    // The press that caused the restart never becomes a jump.
                    r_state      <= RUN;
                    r_game_state <= GS_RUN;
                    r_game_rst   <= 1'b0;
                    r_jump       <= 1'b0;
                    r_duck       <= 1'b0;
                    r_frame_cnt  <= '0;
                    r_step_cnt   <= '0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_game_state <= GS_IDLE;
                end
            endcase
        end
    end

    assign gameState = r_game_state;
    assign jump      = r_jump;
    assign duck      = r_duck;
    assign game_rst  = r_game_rst;
    assign score     = r_score;
    assign hi_score  = r_hi_score;
    assign speed_lvl = r_speed;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl. The driver issues frames and pushes the
// hand-computed output snapshot into exp_q; the monitor pops and compares on
// the falling edge whenever the driver flags a snapshot as due.
module tb_game_state_ctrl;
    import game_pkg::*;

    localparam int EXP_W = 2 + 2 + 3 + 2*SCORE_W + SPEED_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame_tick = 1'b0;
    logic               btn_jump = 1'b0;
    logic               btn_duck = 1'b0;
    logic               collision = 1'b0;
    logic [1:0]         gameState;
    logic               jump, duck, game_rst;
    logic [SCORE_W-1:0] score, hi_score;
    logic [SPEED_W-1:0] speed_lvl;
    state_t             dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    logic             mon_valid = 1'b0;
    int               n_cmp = 0;
    int               n_fail = 0;

    game_state_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_jump   (btn_jump),
        .btn_duck   (btn_duck),
        .collision  (collision),
        .gameState  (gameState),
        .jump       (jump),
        .duck       (duck),
        .game_rst   (game_rst),
        .score      (score),
        .hi_score   (hi_score),
        .speed_lvl  (speed_lvl),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick();
            idle(gap);
        end
    endtask

    task automatic press_jump();
        btn_jump = 1'b1;
        idle(4);
        btn_jump = 1'b0;
        idle(2);
    endtask

    task automatic expect_out(input string nm, input state_t st, input logic [1:0] gs,
                              input logic j, input logic d, input logic r,
                              input int sc, input int hi, input int sp);
        exp_q.push_back({st, gs, j, d, r, SCORE_W'(sc), SCORE_W'(hi), SPEED_W'(sp)});
        name_q.push_back(nm);
        mon_valid = 1'b1;
        @(negedge clk);
        #1;
        mon_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_valid) begin
            logic [EXP_W-1:0] got, exp_v;
            string nm;
            got = {dbg_state, gameState, jump, duck, game_rst, score, hi_score, speed_lvl};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got %h, nothing expected", got);
            end else begin
                exp_v = exp_q.pop_front();
                nm = name_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d gs=%b j=%b d=%b rst=%b sc=%0d hi=%0d sp=%0d / exp st=%0d gs=%b j=%b d=%b rst=%b sc=%0d hi=%0d sp=%0d",
                             nm, got[EXP_W-1 -: 2], got[EXP_W-3 -: 2], got[EXP_W-5], got[EXP_W-6], got[EXP_W-7],
                             got[2*SCORE_W+SPEED_W-1 -: SCORE_W], got[SCORE_W+SPEED_W-1 -: SCORE_W], got[SPEED_W-1:0],
                             exp_v[EXP_W-1 -: 2], exp_v[EXP_W-3 -: 2], exp_v[EXP_W-5], exp_v[EXP_W-6], exp_v[EXP_W-7],
                             exp_v[2*SCORE_W+SPEED_W-1 -: SCORE_W], exp_v[SCORE_W+SPEED_W-1 -: SCORE_W], exp_v[SPEED_W-1:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #(2_000_000);
        n_fail++;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        idle(3);
        expect_out("reset_state", IDLE, GS_IDLE, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(2);

        ticks(3, 1);
        expect_out("idle_no_input", IDLE, GS_IDLE, 0, 0, 0, 0, 0, 0);

        // Collision and duck are ignored while idle.
        collision = 1'b1;
        idle(1);
        collision = 1'b0;
        btn_duck = 1'b1;
        idle(3);
        tick();
        expect_out("idle_coll_duck_ignored", IDLE, GS_IDLE, 0, 0, 0, 0, 0, 0);
        btn_duck = 1'b0;
        idle(3);

        // Start game: jump held for exactly one frame.
        press_jump();
        tick();
        expect_out("start_jump", RUN, GS_RUN, 1, 0, 0, 0, 0, 0);
        tick();
        expect_out("jump_one_frame", RUN, GS_RUN, 0, 0, 0, 0, 0, 0);

        // 252 run frames -> score 42; collision on the tick cycle with a jump edge.
        ticks(251, 1);
        expect_out("score_42", RUN, GS_RUN, 0, 0, 0, 42, 0, 0);
        btn_jump = 1'b1;
        idle(3);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        expect_out("die_42_coll_wins", DEAD, GS_DEAD, 0, 0, 0, 42, 42, 0);
        btn_jump = 1'b0;
        idle(3);

        // Lockout: press at frame 11 and at frame 30 are discarded.
        ticks(10, 1);
        press_jump();
        tick();
        expect_out("lockout_press_early", DEAD, GS_DEAD, 0, 0, 0, 42, 42, 0);
        ticks(18, 1);
        press_jump();
        tick();
        expect_out("lockout_press_last", DEAD, GS_DEAD, 0, 0, 0, 42, 42, 0);
        press_jump();
        tick();
        expect_out("restart_pulse", RESTART, GS_DEAD, 0, 0, 1, 0, 42, 0);
        tick();
        expect_out("restart_to_run", RUN, GS_RUN, 0, 0, 0, 0, 42, 0);

        // Die at 30: best score stays 42.
        ticks(180, 1);
        expect_out("score_30", RUN, GS_RUN, 0, 0, 0, 30, 42, 0);
        collision = 1'b1;
        idle(1);
        collision = 1'b0;
        tick();
        expect_out("die_30_hi_kept", DEAD, GS_DEAD, 0, 0, 0, 30, 42, 0);
        ticks(30, 1);
        press_jump();
        tick();
        expect_out("restart2_pulse", RESTART, GS_DEAD, 0, 0, 1, 0, 42, 0);
        tick();
        expect_out("restart2_run", RUN, GS_RUN, 0, 0, 0, 0, 42, 0);

        // 600 frames -> score 100, first speed step.
        ticks(600, 1);
        expect_out("score_100_speed_1", RUN, GS_RUN, 0, 0, 0, 100, 42, 1);

        // Duck follows the button level; collision forces it low.
        btn_duck = 1'b1;
        idle(3);
        tick();
        expect_out("duck_held", RUN, GS_RUN, 0, 1, 0, 100, 42, 1);
        collision = 1'b1;
        idle(1);
        collision = 1'b0;
        tick();
        expect_out("duck_cleared_on_death", DEAD, GS_DEAD, 0, 0, 0, 100, 100, 1);
        btn_duck = 1'b0;
        idle(3);
        ticks(30, 1);
        press_jump();
        tick();
        expect_out("restart3_pulse", RESTART, GS_DEAD, 0, 0, 1, 0, 100, 0);
        tick();
        expect_out("restart3_run", RUN, GS_RUN, 0, 0, 0, 0, 100, 0);

        // Saturation: 9999*6 frames, speed capped at 7; further frames hold.
        ticks(59994, 0);
        expect_out("score_saturated", RUN, GS_RUN, 0, 0, 0, 9999, 100, 7);
        ticks(12, 0);
        expect_out("score_sat_hold", RUN, GS_RUN, 0, 0, 0, 9999, 100, 7);

        // Reset in the middle of a restart frame.
        collision = 1'b1;
        idle(1);
        collision = 1'b0;
        tick();
        expect_out("die_9999", DEAD, GS_DEAD, 0, 0, 0, 9999, 9999, 7);
        ticks(30, 1);
        press_jump();
        tick();
        expect_out("restart4_pulse", RESTART, GS_DEAD, 0, 0, 1, 0, 9999, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        expect_out("async_reset_mid_restart", IDLE, GS_IDLE, 0, 0, 0, 0, 0, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        tick();
        expect_out("idle_after_reset", IDLE, GS_IDLE, 0, 0, 0, 0, 0, 0);

        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer. Drives gameState, jump, duck and a datapath reset into the dino delegate and obstacle/score logic.
- Samples buttons and collision on the system clock. Commits all game decisions on frame_tick boundaries only.
- Maintains score, hi-score and speed level.

Parameters:
- SCORE_DIV, 6: frames in RUN per score increment.
- SPEED_STEP, 100: score points per speed-level increment.
- SPEED_MAX, 7: speed_lvl saturation value.
- DEAD_LOCKOUT, 30: frames in DEAD before a restart press is accepted.
- SCORE_MAX, 9999: score saturation value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  single-cycle pulse, one per video frame.
- btn_jump  in  1  raw asynchronous button.
- btn_duck  in  1  raw asynchronous button.
- collision  in  1  pixel-overlap flag from renderers; any-cycle assertion counts.
- gameState  out  2  00 IDLE, 10 RUN, 01 DEAD.
- jump  out  1  jump request, held for one frame period.
- duck  out  1  duck level.
- game_rst  out  1  active-high datapath reset, one frame period long.
- score  out  14  binary score.
- hi_score  out  14  binary best score.
- speed_lvl  out  3  obstacle speed level.

Behaviour:
- Reset (async, rst_n=0): state IDLE; gameState=00; jump=0; duck=0; game_rst=0; score=0; hi_score=0; speed_lvl=0; all latches and counters cleared.
- Input conditioning: btn_jump and btn_duck each pass through a 2-FF synchronizer. A rising edge of synced jump sets sticky jump_pend. Collision sets sticky coll_pend. Both sticky flags clear on frame_tick after evaluation. An edge arriving on the frame_tick cycle itself is counted in the current frame.
- All state, output and counter updates below occur only on clk cycles with frame_tick=1. Outputs are registered and stay stable between ticks.
- IDLE:
  - gameState=00.
  - jump_pend -> RUN. jump=1 for the next frame. No game_rst. Score counters cleared.
- RUN:
  - gameState=10. duck = synced btn_duck level, sampled at tick. jump = jump_pend.
  - coll_pend -> DEAD. jump=0, duck=0. Collision wins over a simultaneous jump_pend, which is discarded.
  - Frame counter counts 0..SCORE_DIV-1. On wrap, score+1, saturating at SCORE_MAX.
  - Step counter counts score increments 0..SPEED_STEP-1. On wrap, speed_lvl+1, saturating at SPEED_MAX. A saturated score stops both counters.
- DEAD:
  - gameState=01. Score and speed frozen.
  - On entry, hi_score <= score if score > hi_score; equality leaves it unchanged. Lockout counter loads DEAD_LOCKOUT.
  - Lockout counter decrements per tick. jump_pend is discarded while lockout > 0.
  - At lockout == 0, jump_pend -> RESTART.
- RESTART (internal; gameState stays 01):
  - game_rst=1 for exactly one frame period. score, speed_lvl and counters clear.
  - Next tick: game_rst=0, state RUN, gameState=10, jump=0. The restart press does not become a jump.
- collision during IDLE, DEAD or RESTART is ignored; coll_pend is still cleared at the tick.
- Reset mid-frame or mid-RESTART returns to IDLE immediately and asynchronously, with game_rst=0.
- With no frame_tick, state is held indefinitely and sticky flags remain set.

Decomposition:
- Package game_pkg holds:
  - GS_IDLE=2'b00, GS_RUN=2'b10, GS_DEAD=2'b01.
  - Internal state enum {IDLE, RUN, DEAD, RESTART}.
  - SCORE_W=14, SPEED_W=3.
- Sub-module btn_sync_edge (2-FF synchronizer plus rising-edge pulse), instantiated twice.

Test Plan:
- Reset then 3 ticks with no input -> gameState=00, all outputs 0. Press jump between ticks -> next tick gameState=10, jump=1 for one frame, then 0.
- RUN for 600 frames, SCORE_DIV=6 -> score=100, speed_lvl=1. Force score to 9999 -> score stays 9999 and speed_lvl holds.
- collision and jump edge in the same frame at score=42 -> next tick gameState=01, jump=0, hi_score=42. Then die at 30 -> hi_score stays 42.
- In DEAD, press jump at frame 10 (within lockout) -> stays DEAD, no game_rst. Press after 30 frames -> game_rst=1 for one frame, then gameState=10, score=0, jump=0.
- Assert rst_n=0 during RESTART mid-frame -> immediate gameState=00, game_rst=0, hi_score=0.
- Hold btn_duck in RUN -> duck=1 from the next tick. Collide -> duck=0. Duck in IDLE -> duck stays 0.
